// File: rtl/ifm_tile_reader_if.sv
// Bundle of the DPRAM read port and the output word stream used by ifm_tile_reader.
// The master side is the tile reader; the slave side is the DPRAM plus the downstream feeder.
interface ifm_tile_reader_if #(
  parameter int ADDR_WIDTH  = 19,
  parameter int INOUT_WIDTH = 128
);
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INOUT_WIDTH-1:0] mem_din;
  logic [INOUT_WIDTH-1:0] mem_dout;
  logic [INOUT_WIDTH-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  modport master (
    output mem_we, mem_addr, mem_din, out_data, out_valid, out_last,
    input  mem_dout, out_ready
  );

  modport slave (
    input  mem_we, mem_addr, mem_din, out_data, out_valid, out_last,
    output mem_dout, out_ready
  );
endinterface

// File: rtl/ifm_tile_reader.sv
// Fetches one 32x32x3 input tile from the feature-map DPRAM in channel/column-group/row order
// and streams the 128-bit words through a 2-entry FIFO that hides the 1-cycle read latency.
module ifm_tile_reader #(
  parameter int ADDR_WIDTH  = 19,
  parameter int INOUT_WIDTH = 128,
  parameter int ROW_STRIDE  = 416,
  parameter int CH_STRIDE   = 173056,
  parameter int TILE_H      = 32,
  parameter int COL_GROUPS  = 2,
  parameter int CHANNELS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  ifm_tile_reader_if.master     bus
);

  localparam int RW = (TILE_H     > 1) ? $clog2(TILE_H)     : 1;
  localparam int GW = (COL_GROUPS > 1) ? $clog2(COL_GROUPS) : 1;
  localparam int CW = (CHANNELS   > 1) ? $clog2(CHANNELS)   : 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t ROW_INC = addr_t'(ROW_STRIDE);
  localparam addr_t COL_INC = addr_t'(INOUT_WIDTH / 8);
  localparam addr_t CH_INC  = addr_t'(CH_STRIDE);

  localparam logic [RW-1:0] R_LAST = RW'(TILE_H - 1);
  localparam logic [GW-1:0] G_LAST = GW'(COL_GROUPS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             r_state;
  logic [RW-1:0]          r_row;
  logic [GW-1:0]          r_grp;
  logic [CW-1:0]          r_ch;
  addr_t                  r_addr;
  addr_t                  r_grp_addr;
  addr_t                  r_ch_addr;
  logic                   r_inflight;
  logic                   r_inflight_last;
  logic [INOUT_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]             r_fifo_last;
  logic                   r_rd_ptr;
  logic                   r_wr_ptr;
  logic [1:0]             r_count;

  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occupancy;
  logic       w_issue;
  logic       w_final;
  addr_t      w_grp_next;
  addr_t      w_ch_next;

  // Occupancy counts the word still in the DPRAM pipe, so count + inflight never exceeds 2.
  assign w_pop       = (r_count != 2'd0) & bus.out_ready;
  assign w_push      = r_inflight;
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = (r_state == S_READ) && (w_occupancy < 3'd2);
  assign w_final     = (r_ch == C_LAST) && (r_grp == G_LAST) && (r_row == R_LAST);
  assign w_grp_next  = r_grp_addr + COL_INC;
  assign w_ch_next   = r_ch_addr + CH_INC;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_grp      <= '0;
      r_ch       <= '0;
      r_addr     <= '0;
      r_grp_addr <= '0;
      r_ch_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_READ;
            r_row      <= '0;
            r_grp      <= '0;
            r_ch       <= '0;
            r_addr     <= base_addr;
            r_grp_addr <= base_addr;
            r_ch_addr  <= base_addr;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (w_final) begin
              r_state <= S_DRAIN;
            end else if (r_row == R_LAST) begin
              r_row <= '0;
              if (r_grp == G_LAST) begin
                r_grp      <= '0;
                r_ch       <= r_ch + 1'b1;
                r_ch_addr  <= w_ch_next;
                r_grp_addr <= w_ch_next;
                r_addr     <= w_ch_next;
              end else begin
                r_grp      <= r_grp + 1'b1;
                r_grp_addr <= w_grp_next;
                r_addr     <= w_grp_next;
              end
            end else begin
              r_row  <= r_row + 1'b1;
              r_addr <= r_addr + ROW_INC;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && bus.out_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_final;
    end
  end

  // NOTE: the two FIFO entries are reset because out_data must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
      r_fifo_last <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.mem_dout;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.mem_we    = 1'b0;
  assign bus.mem_din   = '0;
  assign bus.mem_addr  = r_addr;
  assign bus.out_data  = r_fifo_data[r_rd_ptr];
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_last  = bus.out_valid & r_fifo_last[r_rd_ptr];
  assign busy          = (r_state != S_IDLE);
  assign done          = w_pop & bus.out_last;

endmodule

// File: tb/tb_ifm_tile_reader.sv
// Directed bench for ifm_tile_reader: a DPRAM model returns each word's own address,
// so the output stream can be checked against the expected channel/column-group/row address order.
module tb_ifm_tile_reader;

  localparam int AW = 19;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  ifm_tile_reader_if #(.ADDR_WIDTH(AW), .INOUT_WIDTH(DW)) bus ();

  ifm_tile_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // DPRAM model: synchronous read, every word holds its own byte address.
  always @(posedge clk) bus.mem_dout <= {{(DW-AW){1'b0}}, bus.mem_addr};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_addr(input int base, input int k);
    int c;
    int g;
    int r;
    logic [AW-1:0] a;
    c = k / 64;
    g = (k / 32) % 2;
    r = k % 32;
    a = AW'(base + c * 173056 + r * 416 + g * 16);
    return {{(DW-AW){1'b0}}, a};
  endfunction

  // mode 0: out_ready always high; 1: random 50%; 2: low for 10 cycles then high.
  // poke_cyc: cycle at which a start with base 5000 is pulsed while busy (0 = none).
  // stop_after: return after this many words without finishing the tile (0 = full tile).
  task automatic run_tile(input int base, input int mode, input int poke_cyc, input int stop_after);
    int k = 0;
    int cyc = 1;
    bit finished = 0;
    bit seen_valid = 0;
    bit gap = 0;
    bit unstable = 0;
    bit we_seen = 0;
    bit addr_bad = 0;
    bit stray_done = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    bus.out_ready = (mode == 0);
    @(negedge clk);
    start     = 1'b0;
    base_addr = '0;

    while (!finished && cyc < 3000) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (cyc > 10);
      endcase
      if (cyc == poke_cyc) begin
        start     = 1'b1;
        base_addr = AW'(5000);
      end
      #1;
      if (bus.mem_we !== 1'b0) we_seen = 1;
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (cyc == 1) chk("first_mem_addr", bus.mem_addr, exp_addr(base, 0));
      if (mode == 0 && cyc <= 3) chk("valid_latency", bus.out_valid, (cyc == 3));
      if (mode == 0 && cyc <= 192 && bus.mem_addr !== exp_addr(base, cyc - 1)) addr_bad = 1;
      if (mode == 0 && cyc == 193) chk("mem_addr_hold", bus.mem_addr, exp_addr(base, 191));
      if (mode == 2 && cyc == 10) begin
        chk("stall_mem_addr", bus.mem_addr, exp_addr(base, 2));
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_data", bus.out_data, exp_addr(base, 0));
        chk("stall_busy", busy, 1);
      end
      if (prev_stall && bus.out_data !== prev_data) unstable = 1;
      if (mode != 1 && seen_valid && !bus.out_valid) gap = 1;
      if (bus.out_valid) seen_valid = 1;
      if (bus.out_valid && bus.out_ready) begin
        chk("word_data", bus.out_data, exp_addr(base, k));
        chk("word_last", bus.out_last, (k == 191));
        chk("word_done", done, (k == 191));
        k++;
        if (k == 192 || (stop_after != 0 && k == stop_after)) finished = 1;
      end else if (done !== 1'b0) begin
        stray_done = 1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      @(negedge clk);
      start     = 1'b0;
      base_addr = '0;
      cyc++;
    end

    chk("word_count", k, (stop_after != 0) ? stop_after : 192);
    chk("mem_we_zero", we_seen, 0);
    chk("stall_stable", unstable, 0);
    chk("no_stray_done", stray_done, 0);
    if (mode != 1) chk("no_valid_gap", gap, 0);
    if (mode == 0) chk("mem_addr_seq", addr_bad, 0);
    if (stop_after == 0) begin
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_valid", bus.out_valid, 0);
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    rst_n = 1'b1;

    run_tile(0, 0, 0, 0);          // full-throughput tile, address sequence and latency
    run_tile(0, 1, 0, 0);          // random backpressure
    run_tile(520000, 2, 0, 0);     // stall from start, address wraps modulo 2^19
    run_tile(1000, 0, 20, 0);      // start pulse while busy is ignored
    run_tile(7000, 1, 0, 50);      // abandon mid-tile

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_mem_addr", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_valid", bus.out_valid, 0);
    chk("post_rst_busy", busy, 0);

    run_tile(100, 0, 0, 0);        // clean tile after reset, first word from address 100

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
